// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: command encoding, turn FSM states,
// hand arithmetic constants and the debug view of the turn sequencer.
`ifndef GAME_COMMAND_DEFS
`define GAME_COMMAND_DEFS
`define gameCommand logic [1:0]
`define GC_NONE  2'd0
`define GC_HIT   2'd1
`define GC_STAND 2'd2
`endif

package blackjack_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEAL_REQ    = 3'd1,
    DEAL_EVAL   = 3'd2,
    PLAYER_WAIT = 3'd3,
    HIT_REQ     = 3'd4,
    HIT_EVAL    = 3'd5,
    DONE        = 3'd6
  } state_t;

  // Hard total ceiling, point value of tens/faces, soft-ace bonus and the
  // largest hard total that can still take the bonus without busting.
  localparam logic [4:0] HARD_MAX    = 5'd31;
  localparam logic [4:0] FACE_POINTS = 5'd10;
  localparam logic [4:0] ACE_BONUS   = 5'd10;
  localparam logic [4:0] SOFT_LIMIT  = 5'd11;

  // Internal view of the sequencer for observation.
  typedef struct packed {
    state_t     state;
    logic       armed;
    logic       ace;
    logic [4:0] hard;
  } dbg_t;

  // Card points: pips count face value, 10/J/Q/K count ten, ace counts one.
  function automatic logic [4:0] card_points(input logic [3:0] rank);
    return (rank > 4'd10) ? FACE_POINTS : {1'b0, rank};
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Player/card-source bus of the turn sequencer.
// Handshake: the card source may hold i_cardValid at any time; a card moves
// only on a rising edge where o_cardRequest=1, i_cardValid=1 and
// i_cardValue!=0, after which o_cardRequest drops. A player command moves on
// an edge where o_turnIndicator=1 and i_ready=1, but only after i_ready has
// been seen low during the current wait, so a held button acts once.
interface turn_sequencer_if;
  logic              i_dealButtonPushed;
  logic              i_ready;
  `gameCommand       i_command;
  logic              i_cardValid;
  logic [3:0]        i_cardValue;
  logic              o_turnIndicator;
  logic              o_cardRequest;
  logic [4:0]        o_handTotal;
  logic [2:0]        o_cardCount;
  logic              o_bust;
  logic              o_turnDone;

  modport master (
    output i_dealButtonPushed, i_ready, i_command, i_cardValid, i_cardValue,
    input  o_turnIndicator, o_cardRequest, o_handTotal, o_cardCount, o_bust, o_turnDone
  );

  modport slave (
    input  i_dealButtonPushed, i_ready, i_command, i_cardValid, i_cardValue,
    output o_turnIndicator, o_cardRequest, o_handTotal, o_cardCount, o_bust, o_turnDone
  );
endinterface

// File: rtl/hand_accumulator.sv
// Hand arithmetic: saturating hard total, ace flag, card count and the best
// total (one ace promoted to eleven when that does not bust).
module hand_accumulator
  import blackjack_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [3:0] i_rank,
  output logic [4:0] o_hard,
  output logic       o_ace,
  output logic [4:0] o_best,
  output logic [2:0] o_count
);

  logic [4:0] r_hard;
  logic       r_ace;
  logic [2:0] r_count;
  logic [5:0] w_sum;

  assign w_sum = {1'b0, r_hard} + {1'b0, card_points(i_rank)};

  // Clear on a new deal, otherwise fold in each accepted card.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hard  <= '0;
      r_ace   <= 1'b0;
      r_count <= '0;
    end else if (i_clear) begin
      r_hard  <= '0;
      r_ace   <= 1'b0;
      r_count <= '0;
    end else if (i_add) begin
      r_hard <= (w_sum > {1'b0, HARD_MAX}) ? HARD_MAX : w_sum[4:0];
      if (i_rank == 4'd1) r_ace <= 1'b1;
      if (r_count != 3'd7) r_count <= r_count + 3'd1;
    end
  end

  // Best total: promote one ace when the hard total leaves room for it.
  always_comb begin
    o_best = r_hard;
    if (r_ace && (r_hard <= SOFT_LIMIT)) o_best = r_hard + ACE_BONUS;
  end

  assign o_hard  = r_hard;
  assign o_ace   = r_ace;
  assign o_count = r_count;

endmodule

// File: rtl/turn_sequencer.sv
// One player's blackjack turn: deals two cards, takes HIT/STAND commands
// from a debounced button, requests cards and ends on bust, target total,
// card limit or stand.
module turn_sequencer
  import blackjack_pkg::*;
#(
  parameter int BUST_LIMIT = 21,
  parameter int MAX_CARDS  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  turn_sequencer_if.slave    bus,
  output dbg_t               o_dbg
);

  state_t     r_state;
  state_t     w_next;
  logic       r_armed;
  logic       w_deal;
  logic       w_accept;
  logic       w_cmd_take;
  logic       w_end;
  logic       w_bust;
  logic [4:0] w_hard;
  logic       w_ace;
  logic [4:0] w_best;
  logic [2:0] w_count;

  assign w_deal     = ((r_state == IDLE) || (r_state == DONE)) && bus.i_dealButtonPushed;
  assign w_accept   = ((r_state == DEAL_REQ) || (r_state == HIT_REQ)) &&
                      bus.i_cardValid && (bus.i_cardValue != 4'd0);
  assign w_cmd_take = (r_state == PLAYER_WAIT) && r_armed && bus.i_ready;
  assign w_bust     = (w_hard > 5'(BUST_LIMIT));
  assign w_end      = w_bust || (w_best == 5'(BUST_LIMIT)) || (w_count == 3'(MAX_CARDS));

  hand_accumulator u_hand (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_deal),
    .i_add   (w_accept),
    .i_rank  (bus.i_cardValue),
    .o_hard  (w_hard),
    .o_ace   (w_ace),
    .o_best  (w_best),
    .o_count (w_count)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state: deal, card handshakes, evaluation and player commands.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_deal) w_next = DEAL_REQ;
      DEAL_REQ:   if (w_accept) w_next = DEAL_EVAL;
      DEAL_EVAL: begin
        if (w_count < 3'd2) w_next = DEAL_REQ;
        else if (w_end)     w_next = DONE;
        else                w_next = PLAYER_WAIT;
      end
      PLAYER_WAIT: begin
        if (w_cmd_take) begin
          if (bus.i_command == `GC_HIT)        w_next = HIT_REQ;
          else if (bus.i_command == `GC_STAND) w_next = DONE;
        end
      end
      HIT_REQ:  if (w_accept) w_next = HIT_EVAL;
      HIT_EVAL: w_next = w_end ? DONE : PLAYER_WAIT;
      default:  w_next = IDLE;
    endcase
  end

  // Armed flag: cleared on entering the wait, set once the button is seen released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_armed <= 1'b0;
    else if ((r_state != PLAYER_WAIT) && (w_next == PLAYER_WAIT))
      r_armed <= 1'b0;
    else if ((r_state == PLAYER_WAIT) && !bus.i_ready)
      r_armed <= 1'b1;
  end

  // Outputs decoded from state and the hand registers.
  always_comb begin
    bus.o_turnIndicator = (r_state == PLAYER_WAIT);
    bus.o_cardRequest   = (r_state == DEAL_REQ) || (r_state == HIT_REQ);
    bus.o_turnDone      = (r_state == DONE);
    bus.o_handTotal     = w_best;
    bus.o_cardCount     = w_count;
    bus.o_bust          = w_bust;
    o_dbg.state         = r_state;
    o_dbg.armed         = r_armed;
    o_dbg.ace           = w_ace;
    o_dbg.hard          = w_hard;
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: scenario tasks with inline checks.
`ifndef GAME_COMMAND_DEFS
`define GAME_COMMAND_DEFS
`define gameCommand logic [1:0]
`define GC_NONE  2'd0
`define GC_HIT   2'd1
`define GC_STAND 2'd2
`endif

module tb_turn_sequencer;
  import blackjack_pkg::*;

  logic clk;
  logic rst_n;
  dbg_t dbg;
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  turn_sequencer_if bus();

  turn_sequencer #(.BUST_LIMIT(21), .MAX_CARDS(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_dbg   (dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Driver tasks.
  task automatic do_deal;
    bus.i_dealButtonPushed = 1'b1;
    tick();
    bus.i_dealButtonPushed = 1'b0;
  endtask

  task automatic give_card(input logic [3:0] v);
    bit got;
    got = 1'b0;
    bus.i_cardValid = 1'b1;
    bus.i_cardValue = v;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.o_cardRequest) got = 1'b1;
      tick();
    end
    bus.i_cardValid = 1'b0;
    bus.i_cardValue = 4'd0;
    total_cnt++;
    if (!got) begin bad_cnt++; $display("FAIL card_wait: got no request want request for card %0d", v); end
  endtask

  task automatic send_cmd(input logic [1:0] c);
    bus.i_ready = 1'b0;
    tick();
    bus.i_ready   = 1'b1;
    bus.i_command = c;
    tick();
    bus.i_ready   = 1'b0;
    bus.i_command = `GC_NONE;
  endtask

  // Scenarios.
  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.o_turnIndicator, bus.o_cardRequest, bus.o_handTotal, bus.o_cardCount, bus.o_bust, bus.o_turnDone} !== 12'd0)
      begin bad_cnt++; $display("FAIL reset_outputs: got %0h want 0", {bus.o_turnIndicator, bus.o_cardRequest, bus.o_handTotal, bus.o_cardCount, bus.o_bust, bus.o_turnDone}); end
    total_cnt++;
    if (dbg !== dbg_t'(0)) begin bad_cnt++; $display("FAIL reset_dbg: got %0h want 0", dbg); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (dbg.state !== IDLE) begin bad_cnt++; $display("FAIL reset_idle: got %0d want %0d", dbg.state, IDLE); end
  endtask

  task automatic test_stand;
    do_deal();
    total_cnt++;
    if (bus.o_cardRequest !== 1'b1) begin bad_cnt++; $display("FAIL stand_req: got %0d want 1", bus.o_cardRequest); end
    give_card(4'd10);
    total_cnt++;
    if (bus.o_handTotal !== 5'd10) begin bad_cnt++; $display("FAIL stand_first: got %0d want 10", bus.o_handTotal); end
    total_cnt++;
    if (bus.o_cardRequest !== 1'b0) begin bad_cnt++; $display("FAIL stand_req_drop: got %0d want 0", bus.o_cardRequest); end
    give_card(4'd7);
    tick();
    total_cnt++;
    if (bus.o_turnIndicator !== 1'b1) begin bad_cnt++; $display("FAIL stand_turn: got %0d want 1", bus.o_turnIndicator); end
    // Deal push while waiting on the player is ignored.
    bus.i_dealButtonPushed = 1'b1;
    tick();
    bus.i_dealButtonPushed = 1'b0;
    total_cnt++;
    if (dbg.state !== PLAYER_WAIT || bus.o_cardCount !== 3'd2)
      begin bad_cnt++; $display("FAIL stand_deal_ignored: got state %0d count %0d want %0d 2", dbg.state, bus.o_cardCount, PLAYER_WAIT); end
    send_cmd(`GC_STAND);
    total_cnt++;
    if (bus.o_turnDone !== 1'b1 || bus.o_turnIndicator !== 1'b0)
      begin bad_cnt++; $display("FAIL stand_done: got done %0d turn %0d want 1 0", bus.o_turnDone, bus.o_turnIndicator); end
    total_cnt++;
    if (bus.o_handTotal !== 5'd17 || bus.o_cardCount !== 3'd2 || bus.o_bust !== 1'b0)
      begin bad_cnt++; $display("FAIL stand_result: got total %0d count %0d bust %0d want 17 2 0", bus.o_handTotal, bus.o_cardCount, bus.o_bust); end
    repeat (3) tick();
    total_cnt++;
    if (bus.o_handTotal !== 5'd17 || bus.o_cardCount !== 3'd2 || bus.o_turnDone !== 1'b1)
      begin bad_cnt++; $display("FAIL stand_hold: got total %0d count %0d done %0d want 17 2 1", bus.o_handTotal, bus.o_cardCount, bus.o_turnDone); end
  endtask

  task automatic test_blackjack;
    do_deal();
    total_cnt++;
    if (bus.o_handTotal !== 5'd0 || bus.o_cardCount !== 3'd0)
      begin bad_cnt++; $display("FAIL bj_clear: got total %0d count %0d want 0 0", bus.o_handTotal, bus.o_cardCount); end
    give_card(4'd1);
    total_cnt++;
    if (bus.o_handTotal !== 5'd11) begin bad_cnt++; $display("FAIL bj_ace: got %0d want 11", bus.o_handTotal); end
    give_card(4'd13);
    total_cnt++;
    if (bus.o_handTotal !== 5'd21 || bus.o_cardCount !== 3'd2)
      begin bad_cnt++; $display("FAIL bj_total: got total %0d count %0d want 21 2", bus.o_handTotal, bus.o_cardCount); end
    tick();
    total_cnt++;
    if (bus.o_turnDone !== 1'b1 || bus.o_turnIndicator !== 1'b0)
      begin bad_cnt++; $display("FAIL bj_done: got done %0d turn %0d want 1 0", bus.o_turnDone, bus.o_turnIndicator); end
  endtask

  task automatic test_bust;
    do_deal();
    give_card(4'd9);
    give_card(4'd5);
    tick();
    total_cnt++;
    if (bus.o_turnIndicator !== 1'b1 || bus.o_handTotal !== 5'd14)
      begin bad_cnt++; $display("FAIL bust_wait: got turn %0d total %0d want 1 14", bus.o_turnIndicator, bus.o_handTotal); end
    send_cmd(`GC_HIT);
    total_cnt++;
    if (bus.o_cardRequest !== 1'b1 || bus.o_turnIndicator !== 1'b0)
      begin bad_cnt++; $display("FAIL bust_hit_latency: got req %0d turn %0d want 1 0", bus.o_cardRequest, bus.o_turnIndicator); end
    give_card(4'd12);
    total_cnt++;
    if (dbg.hard !== 5'd24 || bus.o_handTotal !== 5'd24 || bus.o_bust !== 1'b1)
      begin bad_cnt++; $display("FAIL bust_total: got hard %0d total %0d bust %0d want 24 24 1", dbg.hard, bus.o_handTotal, bus.o_bust); end
    total_cnt++;
    if (bus.o_turnDone !== 1'b0) begin bad_cnt++; $display("FAIL bust_early_done: got %0d want 0", bus.o_turnDone); end
    tick();
    total_cnt++;
    if (bus.o_turnDone !== 1'b1 || bus.o_bust !== 1'b1)
      begin bad_cnt++; $display("FAIL bust_done: got done %0d bust %0d want 1 1", bus.o_turnDone, bus.o_bust); end
  endtask

  task automatic test_held_button;
    int     entries;
    state_t prev;
    do_deal();
    give_card(4'd2);
    give_card(4'd3);
    tick();
    bus.i_ready = 1'b0;
    tick();
    bus.i_ready     = 1'b1;
    bus.i_command   = `GC_HIT;
    bus.i_cardValid = 1'b1;
    bus.i_cardValue = 4'd4;
    entries = 0;
    prev    = dbg.state;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dbg.state == HIT_REQ && prev != HIT_REQ) entries++;
      prev = dbg.state;
    end
    bus.i_ready     = 1'b0;
    bus.i_command   = `GC_NONE;
    bus.i_cardValid = 1'b0;
    bus.i_cardValue = 4'd0;
    total_cnt++;
    if (entries !== 1) begin bad_cnt++; $display("FAIL held_hits: got %0d want 1", entries); end
    total_cnt++;
    if (bus.o_cardCount !== 3'd3 || bus.o_handTotal !== 5'd9 || dbg.state !== PLAYER_WAIT)
      begin bad_cnt++; $display("FAIL held_result: got count %0d total %0d state %0d want 3 9 %0d", bus.o_cardCount, bus.o_handTotal, dbg.state, PLAYER_WAIT); end
    send_cmd(`GC_STAND);
    total_cnt++;
    if (bus.o_turnDone !== 1'b1) begin bad_cnt++; $display("FAIL held_stand: got %0d want 1", bus.o_turnDone); end
  endtask

  task automatic test_max_cards;
    do_deal();
    bus.i_cardValid = 1'b1;
    bus.i_cardValue = 4'd0;
    repeat (3) tick();
    bus.i_cardValid = 1'b0;
    total_cnt++;
    if (bus.o_cardRequest !== 1'b1 || bus.o_cardCount !== 3'd0)
      begin bad_cnt++; $display("FAIL zero_rank: got req %0d count %0d want 1 0", bus.o_cardRequest, bus.o_cardCount); end
    give_card(4'd1);
    give_card(4'd2);
    tick();
    total_cnt++;
    if (bus.o_turnIndicator !== 1'b1 || bus.o_handTotal !== 5'd13)
      begin bad_cnt++; $display("FAIL max_deal: got turn %0d total %0d want 1 13", bus.o_turnIndicator, bus.o_handTotal); end
    for (int k = 0; k < 3; k++) begin
      send_cmd(`GC_HIT);
      give_card(4'd2);
      tick();
      total_cnt++;
      if (bus.o_handTotal !== 5'(15 + 2 * k) || bus.o_cardCount !== 3'(3 + k) ||
          dbg.state !== ((k < 2) ? PLAYER_WAIT : DONE))
        begin bad_cnt++; $display("FAIL max_hit%0d: got total %0d count %0d state %0d want %0d %0d %0d",
          k, bus.o_handTotal, bus.o_cardCount, dbg.state, 15 + 2 * k, 3 + k, (k < 2) ? PLAYER_WAIT : DONE); end
    end
  endtask

  task automatic test_reset_mid;
    do_deal();
    give_card(4'd10);
    tick();
    total_cnt++;
    if (bus.o_cardRequest !== 1'b1) begin bad_cnt++; $display("FAIL mid_req: got %0d want 1", bus.o_cardRequest); end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.o_turnIndicator, bus.o_cardRequest, bus.o_handTotal, bus.o_cardCount, bus.o_bust, bus.o_turnDone} !== 12'd0 || dbg !== dbg_t'(0))
      begin bad_cnt++; $display("FAIL mid_reset: got req %0d count %0d dbg %0h want all 0", bus.o_cardRequest, bus.o_cardCount, dbg); end
    #2 rst_n = 1'b1;
    bus.i_cardValid = 1'b1;
    bus.i_cardValue = 4'd5;
    repeat (5) tick();
    bus.i_cardValid = 1'b0;
    bus.i_cardValue = 4'd0;
    total_cnt++;
    if (dbg.state !== IDLE || bus.o_cardCount !== 3'd0 || bus.o_cardRequest !== 1'b0 || bus.o_handTotal !== 5'd0)
      begin bad_cnt++; $display("FAIL mid_stale: got state %0d count %0d req %0d total %0d want %0d 0 0 0",
        dbg.state, bus.o_cardCount, bus.o_cardRequest, bus.o_handTotal, IDLE); end
  endtask

  initial begin
    bus.i_dealButtonPushed = 1'b0;
    bus.i_ready            = 1'b0;
    bus.i_command          = `GC_NONE;
    bus.i_cardValid        = 1'b0;
    bus.i_cardValue        = 4'd0;
    rst_n                  = 1'b0;
    test_reset();
    test_stand();
    test_blackjack();
    test_bust();
    test_held_button();
    test_max_cards();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
